// File: rtl/cpu_result_logger.sv
// CPU status snapshot logger: captures changed status bytes into a small FIFO and
// sends them out as UART-style frames. Define LOGGER_PARITY_EN to add an even parity bit.
module cpu_result_logger #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] status_in,
    input  logic       capture_en,
    input  logic       drop_clr,
    output logic       tx,
    output logic       tx_busy,
    output logic [3:0] fifo_count,
    output logic       dropped
);

    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = 8;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  FULL_COUNT = 4'(FIFO_DEPTH);

`ifdef LOGGER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       last_status;
    logic             captured;

    tx_state_t        state;
    tx_state_t        state_nx;
    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] clk_cnt_nx;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_nx;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nx;
    logic             tx_nx;
    logic             busy_nx;

    logic             full_c;
    logic             capture_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;
    logic             bit_end_c;

    // Change detection and FIFO admission; a pop on the same edge frees a slot.
    always_comb begin
        full_c    = (fifo_count == FULL_COUNT);
        capture_c = capture_en && (!captured || (status_in != last_status));
        push_c    = capture_c && (!full_c || pop_c);
        drop_c    = capture_c && full_c && !pop_c;
    end

    // Transmitter next-state, pop request and registered-output precomputation.
    always_comb begin
        state_nx   = state;
        clk_cnt_nx = clk_cnt + CNT_W'(1);
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        pop_c      = 1'b0;
        bit_end_c  = (clk_cnt == BIT_LAST);

        case (state)
            IDLE: begin
                clk_cnt_nx = '0;
                if (fifo_count != 4'd0) begin
                    pop_c    = 1'b1;
                    shreg_nx = mem[rd_ptr];
                    state_nx = START;
                end
            end
            START: begin
                if (bit_end_c) begin
                    clk_cnt_nx = '0;
                    bit_idx_nx = 3'd0;
                    state_nx   = DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    clk_cnt_nx = '0;
                    if (bit_idx == 3'd7) begin
`ifdef LOGGER_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
`ifdef LOGGER_PARITY_EN
            PARITY: begin
                if (bit_end_c) begin
                    clk_cnt_nx = '0;
                    state_nx   = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end_c) begin
                    clk_cnt_nx = '0;
                    if (fifo_count != 4'd0) begin
                        pop_c    = 1'b1;
                        shreg_nx = mem[rd_ptr];
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                clk_cnt_nx = '0;
                state_nx   = IDLE;
            end
        endcase

        // Line level follows the state being entered so tx lines up with the state.
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shreg_nx[bit_idx_nx];
`ifdef LOGGER_PARITY_EN
            PARITY:  tx_nx = ^shreg_nx;
`endif
            default: tx_nx = 1'b1;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            dropped     <= 1'b0;
            last_status <= '0;
            captured    <= 1'b0;
        end else begin
            state      <= state_nx;
            clk_cnt    <= clk_cnt_nx;
            bit_idx    <= bit_idx_nx;
            shreg      <= shreg_nx;
            tx         <= tx_nx;
            tx_busy    <= busy_nx;
            fifo_count <= fifo_count + 4'(push_c) - 4'(pop_c);
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (capture_c) begin
                last_status <= status_in;
                captured    <= 1'b1;
            end
            if (drop_clr)    dropped <= 1'b0;
            else if (drop_c) dropped <= 1'b1;
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (rst_n && push_c) mem[wr_ptr] <= status_in;
    end

endmodule

// File: tb/tb_cpu_result_logger.sv
// Self-checking bench for cpu_result_logger: directed scenarios plus random traffic
// compared every cycle against a queue-and-frame-timer reference model.
module tb_cpu_result_logger;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
`ifdef LOGGER_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] status_in = 8'h00;
    logic       capture_en = 1'b0;
    logic       drop_clr = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic [3:0] fifo_count;
    logic       dropped;

    cpu_result_logger #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .status_in  (status_in),
        .capture_en (capture_en),
        .drop_clr   (drop_clr),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending snapshots, current frame byte and frame cycles left.
    logic [7:0] q[$];
    bit         have = 0;
    logic [7:0] last = 8'h00;
    int         rem = 0;
    logic [7:0] cur = 8'h00;
    bit         drp = 0;

    function automatic logic exp_tx();
        int k;
        if (rem == 0) return 1'b1;
        k = (FRAME - rem) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
        if (k == 9 && NBITS == 11) return ^cur;
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit pop, cap, drop_evt;
        if (!rst_n) begin
            q.delete();
            have = 0;
            rem  = 0;
            drp  = 0;
            return;
        end
        pop      = (rem <= 1) && (q.size() > 0);
        cap      = capture_en && (!have || status_in != last);
        drop_evt = 0;
        if (pop) cur = q.pop_front();
        if (cap) begin
            last = status_in;
            have = 1;
            if (q.size() < DEPTH) q.push_back(status_in);
            else drop_evt = 1;
        end
        if (drop_clr) drp = 0;
        else if (drop_evt) drp = 1;
        if (rem <= 1) rem = pop ? FRAME : 0;
        else rem = rem - 1;
    endtask

    task automatic check();
        logic       e_tx, e_busy, e_drp;
        logic [3:0] e_cnt;
        e_tx   = exp_tx();
        e_busy = (rem > 0);
        e_cnt  = 4'(q.size());
        e_drp  = drp;
        vectors++;
        assert (tx === e_tx) else begin
            miscompares++;
            $error("FAIL tx: observed %b expected %b at %0t", tx, e_tx, $time);
        end
        assert (tx_busy === e_busy) else begin
            miscompares++;
            $error("FAIL tx_busy: observed %b expected %b at %0t", tx_busy, e_busy, $time);
        end
        assert (fifo_count === e_cnt) else begin
            miscompares++;
            $error("FAIL fifo_count: observed %0d expected %0d at %0t", fifo_count, e_cnt, $time);
        end
        assert (dropped === e_drp) else begin
            miscompares++;
            $error("FAIL dropped: observed %b expected %b at %0t", dropped, e_drp, $time);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [7:0] s, input logic clr);
        @(negedge clk);
        rst_n      = r;
        capture_en = en;
        status_in  = s;
        drop_clr   = clr;
        @(posedge clk);
        model_edge();
        #1;
        check();
    endtask

    task automatic do_reset();
        repeat (2) step(1'b0, 1'b1, 8'h5A, 1'b0);
    endtask

    initial begin
        logic [7:0] b;

        // Reset state, with capture_en high to show it is ignored in reset.
        do_reset();

        // Single held value: exactly one frame of 0x12.
        repeat (FRAME + 10) step(1'b1, 1'b1, 8'h12, 1'b0);

        // Two values one cycle apart: back-to-back frames.
        do_reset();
        step(1'b1, 1'b1, 8'h12, 1'b0);
        repeat (2 * FRAME + 10) step(1'b1, 1'b1, 8'h34, 1'b0);

        // Six distinct bytes back to back: fill, drop, then clear the flag.
        do_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, 8'(i * 8'h11), 1'b0);
        repeat (10) step(1'b1, 1'b1, 8'h66, 1'b0);
        step(1'b1, 1'b1, 8'h66, 1'b1);
        repeat (5 * FRAME) step(1'b1, 1'b1, 8'h66, 1'b0);

        // Capture disabled while status changes.
        do_reset();
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (20) step(1'b1, 1'b0, 8'hA5, 1'b0);

        // Reset in the middle of a 0xFF frame, then recapture of 0xFF.
        do_reset();
        repeat (CPB + 12) step(1'b1, 1'b1, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 8'hFF, 1'b0);
        repeat (FRAME + 10) step(1'b1, 1'b1, 8'hFF, 1'b0);

        // Full FIFO with a push landing on the end-of-STOP pop edge.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0);
        repeat (FRAME - 4) step(1'b1, 1'b1, 8'hA4, 1'b0);
        step(1'b1, 1'b1, 8'hB5, 1'b0);
        repeat (6 * FRAME) step(1'b1, 1'b1, 8'hB5, 1'b0);

        // Random traffic from a small value set so repeats and drops are common.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            b = 8'($urandom_range(0, 5) * 37);
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0), b,
                 ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_result_logger.md
CPU_RESULT_LOGGER -- requirements
Module: cpu_result_logger

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clocks per serial bit (legal range 2..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, snapshot entries (power of two, 2..8).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port status_in, input, 8, CPU status byte: [3:0] ALU result, [7] carry, [6] zero, [5] overflow, [4] spare.
REQ-006 SHALL have port capture_en, input, 1, enables snapshot capture.
REQ-007 SHALL have port drop_clr, input, 1, clears the sticky drop flag.
REQ-008 SHALL have port tx, output, 1, serial line; idle high.
REQ-009 SHALL have port tx_busy, output, 1, high while a frame is being sent.
REQ-010 SHALL have port fifo_count, output, 4, number of queued snapshots.
REQ-011 SHALL have port dropped, output, 1, sticky flag set when a capture is lost.

Function
REQ-012 SHALL capture status_in on a rising edge when capture_en=1 and either no snapshot has been taken since reset or status_in differs from the last captured byte.
REQ-013 SHALL compare all 8 bits, including [4], for change detection; the last-captured register updates only on an accepted or dropped capture.
REQ-014 SHALL push each capture into a FIFO_DEPTH-entry FIFO; fifo_count reflects the push on the following cycle.
REQ-015 SHALL, when a capture occurs with the FIFO full and no pop on the same edge, discard it, leave FIFO contents unchanged and set dropped=1.
REQ-016 SHALL, on simultaneous push and pop with the FIFO full, accept the push; fifo_count stays unchanged.
REQ-017 SHALL implement transmitter FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-018 SHALL, in IDLE with fifo_count>0, pop the head entry on the next edge and enter START; tx_busy=1 from that edge until STOP completes.
REQ-019 SHALL hold tx low for CLKS_PER_BIT clocks in START, send 8 data bits LSB-first for CLKS_PER_BIT clocks each in DATA, and hold tx high for CLKS_PER_BIT clocks in STOP.
REQ-020 SHALL, at the end of STOP, go to START directly (popping the next entry on the same edge) if the FIFO is non-empty, else to IDLE with tx_busy=0.
REQ-021 SHALL keep tx=1 in IDLE; an empty FIFO never causes a pop.
REQ-022 SHALL give drop_clr priority over a same-cycle drop event (dropped clears).
REQ-023 SHALL let fifo_count wrap-free: range 0..FIFO_DEPTH only.

Reset
REQ-024 SHALL, on rising edge with rst_n=0, set tx=1, tx_busy=0, fifo_count=0, dropped=0, FSM=IDLE, bit/clock counters=0, and clear the "captured-since-reset" flag.
REQ-025 SHALL abort any frame in progress on reset; tx is high from the reset edge, with no partial stop bit.
REQ-026 SHALL ignore capture_en during cycles with rst_n=0.

Configuration
REQ-027 SHALL, with macro LOGGER_PARITY_EN defined, insert a PARITY state after DATA for CLKS_PER_BIT clocks driving even parity of the 8 data bits (frame = 11 bits).
REQ-028 SHALL, without LOGGER_PARITY_EN, omit the PARITY state entirely (frame = 10 bits, DATA goes straight to STOP).

Verification
REQ-029 SHALL cover: reset, capture_en=1, status_in=0x12 held -> exactly one capture; tx frame 0,0,1,0,0,1,0,0,0,1 at 4 clocks/bit; tx_busy high 40 clocks (44 with parity, parity bit 0).
REQ-030 SHALL cover: status_in 0x12 then 0x34 one cycle apart -> two frames back-to-back, second START immediately after first STOP, no idle gap.
REQ-031 SHALL cover: 6 distinct bytes on consecutive cycles while the transmitter is busy -> fifo_count reaches 4, dropped=1, only the first 5 bytes transmitted (1 popped plus 4 queued); drop_clr -> dropped=0.
REQ-032 SHALL cover: capture_en=0 while status_in changes 0x00->0xA5 -> fifo_count stays 0, tx stays 1.
REQ-033 SHALL cover: rst_n=0 asserted mid-DATA of a 0xFF frame -> next edge tx=1, tx_busy=0, fifo_count=0; after release, status 0xFF recaptured as the first snapshot.
REQ-034 SHALL cover: FIFO full with a push and an end-of-STOP pop on the same edge -> push accepted, fifo_count stays 4, dropped stays 0.
